// File: rtl/sisc_pkg.sv
// Shared constants and types for the SISC execute/control core: opcodes,
// ALU functs, ALU mode encodings, FSM states and status bit positions.
package sisc_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ALU = 4'b0001;
    localparam logic [3:0] OP_ADI = 4'b0010;
    localparam logic [3:0] OP_BRA = 4'b0100;
    localparam logic [3:0] OP_BRR = 4'b0101;
    localparam logic [3:0] OP_BNE = 4'b0110;
    localparam logic [3:0] OP_BNR = 4'b0111;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [3:0] F_ADD = 4'b0001;
    localparam logic [3:0] F_SUB = 4'b0010;
    localparam logic [3:0] F_NOT = 4'b0011;
    localparam logic [3:0] F_OR  = 4'b0100;
    localparam logic [3:0] F_AND = 4'b0101;
    localparam logic [3:0] F_XOR = 4'b0110;
    localparam logic [3:0] F_SHL = 4'b0111;
    localparam logic [3:0] F_SHR = 4'b1000;

    typedef enum logic [1:0] {
        ALU_RR   = 2'b00,
        ALU_ADDI = 2'b01,
        ALU_PASS = 2'b10,
        ALU_ZERO = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_START0,
        ST_START1,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    // Only the defined reg-reg functs touch the status register.
    function automatic logic funct_updates_stat(input logic [3:0] f);
        return (f >= F_ADD) && (f <= F_SHR);
    endfunction

endpackage

// File: rtl/sisc_alu_core.sv
// Combinational 32-bit ALU with {C,V,N,Z} flag generation and an
// indication of whether the selected operation updates the status register.
module sisc_alu_core
    import sisc_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [3:0]  funct,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [15:0] imm,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        updates
);

    logic [31:0] add_b;
    logic [32:0] sum;
    logic [32:0] diff;
    logic        add_v;
    logic        sub_v;
    logic        c_flag;
    logic        v_flag;

    always_comb begin
        add_b = (alu_op == ALU_ADDI) ? {{16{imm[15]}}, imm} : rsb;
        sum   = {1'b0, rsa} + {1'b0, add_b};
        // Carry out of the two's-complement subtract is the "no borrow" flag.
        diff  = {1'b0, rsa} + {1'b0, ~rsb} + 33'd1;
        add_v = (rsa[31] == add_b[31]) && (sum[31] != rsa[31]);
        sub_v = (rsa[31] != rsb[31]) && (diff[31] != rsa[31]);

        result  = rsa;
        c_flag  = 1'b0;
        v_flag  = 1'b0;
        updates = 1'b0;

        case (alu_op)
            ALU_RR: begin
                updates = funct_updates_stat(funct);
                case (funct)
                    F_ADD: begin
                        result = sum[31:0];
                        c_flag = sum[32];
                        v_flag = add_v;
                    end
                    F_SUB: begin
                        result = diff[31:0];
                        c_flag = diff[32];
                        v_flag = sub_v;
                    end
                    F_NOT:   result = ~rsa;
                    F_OR:    result = rsa | rsb;
                    F_AND:   result = rsa & rsb;
                    F_XOR:   result = rsa ^ rsb;
                    F_SHL:   result = rsa << rsb[4:0];
                    F_SHR:   result = rsa >> rsb[4:0];
                    default: result = rsa;
                endcase
            end
            ALU_ADDI: begin
                result  = sum[31:0];
                c_flag  = sum[32];
                v_flag  = add_v;
                updates = 1'b1;
            end
            ALU_PASS: result = rsa;
            default:  result = 32'd0;
        endcase

        flags         = 4'd0;
        flags[STAT_C] = c_flag;
        flags[STAT_V] = v_flag;
        flags[STAT_N] = result[31];
        flags[STAT_Z] = (result == 32'd0);
    end

endmodule

// File: rtl/sisc_exec_ctrl.sv
// SISC control/execute core: instruction-sequencing FSM, ALU instance and
// branch-target adder. Datapath controls decode combinationally from state.
module sisc_exec_ctrl
    import sisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] instr,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [3:0]  stat,
    input  logic [15:0] pc_in,
    output logic [31:0] alu_result,
    output logic [3:0]  stat_in,
    output logic        stat_en,
    output logic [15:0] br_addr,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        br_sel,
    output logic        pc_sel,
    output logic        pc_write,
    output logic        pc_rst,
    output logic        ir_load
);

    state_e      state_q;
    state_e      state_d;

    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic [3:0]  funct;
    logic        is_branch;
    logic        is_relative;
    logic        br_taken;
    logic        alu_updates;
    logic        unused_rd;

    assign opcode    = instr[31:28];
    assign mm        = instr[27:24];
    assign imm       = instr[15:0];
    assign funct     = instr[3:0];
    assign unused_rd = ^instr[23:20];

    always_comb begin
        is_branch   = 1'b0;
        is_relative = 1'b0;
        br_taken    = 1'b0;
        case (opcode)
            OP_BRA, OP_BRR: begin
                is_branch = 1'b1;
                br_taken  = (stat & mm) != 4'd0;
            end
            OP_BNE, OP_BNR: begin
                is_branch = 1'b1;
                br_taken  = (stat & mm) == 4'd0;
            end
            default: ;
        endcase
        is_relative = (opcode == OP_BRR) || (opcode == OP_BNR);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START0:    state_d = ST_START1;
            ST_START1:    state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE:    state_d = (opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_MEM;
            ST_MEM:       state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            default:      state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= ST_START0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        alu_op   = ALU_PASS;
        stat_en  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_sel   = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        ir_load  = 1'b0;

        // ALU mode is held from EXECUTE through WRITEBACK so the write-back
        // data stays stable while the register file captures it.
        if (state_q == ST_EXECUTE || state_q == ST_MEM || state_q == ST_WRITEBACK) begin
            case (opcode)
                OP_ALU:  alu_op = ALU_RR;
                OP_ADI:  alu_op = ALU_ADDI;
                default: alu_op = ALU_PASS;
            endcase
        end

        case (state_q)
            ST_START0: pc_rst = 1'b1;
            ST_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            ST_DECODE: begin
                if (is_branch && br_taken) begin
                    pc_sel   = 1'b1;
                    pc_write = 1'b1;
                    br_sel   = is_relative;
                end
            end
            ST_EXECUTE: stat_en = ((opcode == OP_ALU) || (opcode == OP_ADI)) && alu_updates;
            ST_WRITEBACK: rf_we = (opcode == OP_ALU) || (opcode == OP_ADI);
            default: ;
        endcase
    end

    assign br_addr = br_sel ? (pc_in + imm) : imm;

    sisc_alu_core u_alu (
        .alu_op  (alu_op),
        .funct   (funct),
        .rsa     (rsa),
        .rsb     (rsb),
        .imm     (imm),
        .result  (alu_result),
        .flags   (stat_in),
        .updates (alu_updates)
    );

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Directed bench for sisc_exec_ctrl: reset sequencing, ALU results/flags,
// branch decisions, HALT behaviour and reset in mid-instruction.
`timescale 1ns/1ps
module tb_sisc_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [31:0] instr;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [3:0]  stat;
    logic [15:0] pc_in;
    logic [31:0] alu_result;
    logic [3:0]  stat_in;
    logic        stat_en;
    logic [15:0] br_addr;
    logic [1:0]  alu_op;
    logic        rf_we;
    logic        wb_sel;
    logic        br_sel;
    logic        pc_sel;
    logic        pc_write;
    logic        pc_rst;
    logic        ir_load;
    logic [7:0]  ctl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctl = {rf_we, wb_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load, stat_en};

    sisc_exec_ctrl dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .instr      (instr),
        .rsa        (rsa),
        .rsb        (rsb),
        .stat       (stat),
        .pc_in      (pc_in),
        .alu_result (alu_result),
        .stat_in    (stat_in),
        .stat_en    (stat_en),
        .br_addr    (br_addr),
        .alu_op     (alu_op),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .br_sel     (br_sel),
        .pc_sel     (pc_sel),
        .pc_write   (pc_write),
        .pc_rst     (pc_rst),
        .ir_load    (ir_load)
    );

    task automatic chk(input string pfx, input string name,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s_%s observed=%0h expected=%0h", pfx, name, obs, exp);
            $error("check %s_%s", pfx, name);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts in FETCH, walks one ALU/ADI instruction, ends in the next FETCH.
    task automatic run_alu(input string tag, input logic [31:0] ins,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [3:0] st,
                           input logic se, input logic [1:0] op);
        instr = ins;
        rsa   = a;
        rsb   = b;
        tick();
        chk(tag, "dec_ctl", ctl, 8'h00);
        tick();
        chk(tag, "ex_op", alu_op, op);
        chk(tag, "ex_res", alu_result, res);
        chk(tag, "ex_stat", stat_in, st);
        chk(tag, "ex_stat_en", stat_en, se);
        chk(tag, "ex_rf_we", rf_we, 1'b0);
        tick();
        chk(tag, "mem_ctl", ctl, 8'h00);
        chk(tag, "mem_op", alu_op, op);
        tick();
        chk(tag, "wb_ctl", ctl, 8'h80);
        chk(tag, "wb_op", alu_op, op);
        chk(tag, "wb_res", alu_result, res);
        tick();
        chk(tag, "fetch_ctl", ctl, 8'h0A);
        $display("txn %s instr=%08h rsa=%08h rsb=%08h result=%08h stat=%04b", tag, ins, a, b, res, st);
    endtask

    task automatic run_br(input string tag, input logic [31:0] ins,
                          input logic [15:0] pcv, input logic [3:0] stv,
                          input logic taken, input logic bsel, input logic [15:0] baddr);
        instr = ins;
        pc_in = pcv;
        stat  = stv;
        tick();
        chk(tag, "dec_pc_write", pc_write, taken);
        chk(tag, "dec_pc_sel", pc_sel, taken);
        chk(tag, "dec_ir_load", ir_load, 1'b0);
        if (taken) begin
            chk(tag, "dec_br_sel", br_sel, bsel);
            chk(tag, "dec_br_addr", br_addr, baddr);
        end
        tick();
        chk(tag, "ex_ctl", ctl, 8'h00);
        chk(tag, "ex_op", alu_op, 2'b10);
        tick();
        tick();
        chk(tag, "wb_ctl", ctl, 8'h00);
        tick();
        chk(tag, "fetch_ctl", ctl, 8'h0A);
        $display("txn %s instr=%08h pc_in=%04h stat=%04b taken=%0b br_addr=%04h", tag, ins, pcv, stv, taken, baddr);
    endtask

    initial begin
        rst_f = 1'b0;
        instr = 32'd0;
        rsa   = 32'd0;
        rsb   = 32'd0;
        stat  = 4'd0;
        pc_in = 16'd0;

        tick();
        tick();
        chk("rst", "ctl", ctl, 8'h04);
        chk("rst", "alu_op", alu_op, 2'b10);
        $display("txn reset held 2 cycles ctl=%02h", ctl);

        rst_f = 1'b1;
        tick();
        chk("rel1", "ctl", ctl, 8'h00);
        tick();
        chk("rel2", "fetch_ctl", ctl, 8'h0A);
        $display("txn reset released, fetch after 2 cycles");

        run_alu("add_ovf", 32'h1031_2001, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110, 1'b1, 2'b00);
        run_alu("adi",     32'h2010_FFFB, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 4'b1001, 1'b1, 2'b01);
        run_alu("sub_eq",  32'h1031_2002, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 4'b1001, 1'b1, 2'b00);
        run_alu("sub_lt",  32'h1031_2002, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFF, 4'b0010, 1'b1, 2'b00);
        run_alu("xor",     32'h1031_2006, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 4'b0000, 1'b1, 2'b00);
        run_alu("shl",     32'h1031_2007, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0000, 1'b1, 2'b00);
        run_alu("shr",     32'h1031_2008, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000, 1'b1, 2'b00);
        run_alu("badfn",   32'h1031_2000, 32'h1234_5678, 32'h0000_0001, 32'h1234_5678, 4'b0000, 1'b0, 2'b00);

        run_br("brr_tk",  32'h5100_0004, 16'hFFFE, 4'b0001, 1'b1, 1'b1, 16'h0002);
        run_br("brr_nt",  32'h5200_0004, 16'hFFFE, 4'b0001, 1'b0, 1'b1, 16'h0002);
        run_br("bne_mm0", 32'h6000_1234, 16'h0100, 4'b1111, 1'b1, 1'b0, 16'h1234);
        run_br("bnr_nt",  32'h7300_0010, 16'h0100, 4'b0001, 1'b0, 1'b1, 16'h0110);

        instr = 32'hF000_0000;
        tick();
        chk("hlt", "dec_ctl", ctl, 8'h00);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("halt", "ctl", ctl, 8'h00);
            chk("halt", "alu_op", alu_op, 2'b10);
        end
        $display("txn HLT held 12 cycles ctl=%02h", ctl);

        rst_f = 1'b0;
        tick();
        chk("halt_rst", "ctl", ctl, 8'h04);
        rst_f = 1'b1;
        tick();
        tick();
        chk("halt_rst", "fetch_ctl", ctl, 8'h0A);
        $display("txn reset from HALT, fetch resumed");

        instr = 32'h1031_2001;
        rsa   = 32'h0000_0001;
        rsb   = 32'h0000_0001;
        tick();
        tick();
        chk("mid_rst", "ex_stat_en", stat_en, 1'b1);
        rst_f = 1'b0;
        tick();
        chk("mid_rst", "ctl", ctl, 8'h04);
        rst_f = 1'b1;
        tick();
        chk("mid_rst", "start1_ctl", ctl, 8'h00);
        tick();
        chk("mid_rst", "fetch_ctl", ctl, 8'h0A);
        $display("txn reset during EXECUTE, no write-back");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
